mac_acc_block: RTL and testbench

//  Accumulate stage directly downstream of the four mac_mul_block_0..3 partial-product units.
//  - Combines their 40-bit outputs (C0..C3) according to the lane config.
//  - Adds the combined products into a 160-bit segmented accumulator: 4x40 / 2x80 / 1x160 lanes.
//  - Presents the running sums to the MAC output / readback path.
//  - Two-stage pipeline: combine register, then accumulate register.

---
 rtl/mac_acc_block_pkg.sv | 16 +
 rtl/mac_seg_adder.sv | 28 ++
 rtl/mac_acc_block.sv | 83 ++++++++
 tb/tb_mac_acc_block.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_block_pkg.sv
// Shared constants and lane-configuration encoding for the MAC accumulate stage.
package mac_acc_block_pkg;

  localparam int MAC_CONF_WIDTH = 3;
  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH;
  localparam int MAC_ACC_WIDTH  = 4 * MAC_INT_WIDTH;

  typedef enum logic [1:0] {
    MAC_SINGLE    = 2'b00,
    MAC_DUAL      = 2'b01,
    MAC_QUAD      = 2'b10,
    MAC_CFG_UNDEF = 2'b11
  } mac_cfg_e;

endpackage

// File: rtl/mac_seg_adder.sv
// 160-bit adder built from four 40-bit slices; carries between slices are
// killed at lane boundaries selected by cfg.
module mac_seg_adder
  import mac_acc_block_pkg::*;
(
  input  logic [MAC_ACC_WIDTH-1:0] a,
  input  logic [MAC_ACC_WIDTH-1:0] b,
  input  logic [1:0]               cfg,
  output logic [MAC_ACC_WIDTH-1:0] sum
);

  logic kill40, kill80, kill120;
  logic [MAC_INT_WIDTH:0]   s0, s1, s2;
  logic [MAC_INT_WIDTH-1:0] s3;

  // Undefined cfg behaves like SINGLE: every slice is isolated.
  assign kill80  = (cfg != MAC_QUAD);
  assign kill40  = (cfg != MAC_DUAL) && (cfg != MAC_QUAD);
  assign kill120 = kill40;

  assign s0 = {1'b0, a[39:0]}    + {1'b0, b[39:0]};
  assign s1 = {1'b0, a[79:40]}   + {1'b0, b[79:40]}   + {40'd0, s0[40] & ~kill40};
  assign s2 = {1'b0, a[119:80]}  + {1'b0, b[119:80]}  + {40'd0, s1[40] & ~kill80};
  assign s3 = a[159:120] + b[159:120] + {39'd0, s2[40] & ~kill120};

  assign sum = {s3, s2[39:0], s1[39:0], s0[39:0]};

endmodule

// File: rtl/mac_acc_block.sv
// Two-stage accumulate stage: recombine the four partial products into lanes,
// then add (or load) them into a segmented 160-bit accumulator.
module mac_acc_block
  import mac_acc_block_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic [MAC_INT_WIDTH-1:0]  C0,
  input  logic [MAC_INT_WIDTH-1:0]  C1,
  input  logic [MAC_INT_WIDTH-1:0]  C2,
  input  logic [MAC_INT_WIDTH-1:0]  C3,
  output logic [MAC_ACC_WIDTH-1:0]  acc_out,
  output logic                      valid_out,
  output logic [1:0]                cfg_out
);

  logic [MAC_ACC_WIDTH-1:0] p_comb, p1, acc_sum;
  logic [79:0]              dual_lo, dual_hi;
  logic [MAC_ACC_WIDTH-1:0] quad_sum;
  logic                     clr1, v1;
  logic [1:0]               cfg1;
  logic                     unused_cfg;

  assign unused_cfg = cfg[2];

  assign dual_lo  = {40'd0, C0} + {32'd0, C1, 8'd0};
  assign dual_hi  = {40'd0, C2} + {32'd0, C3, 8'd0};
  assign quad_sum = {120'd0, C0} + {112'd0, C1, 8'd0}
                  + {104'd0, C2, 16'd0} + {96'd0, C3, 24'd0};

  always_comb begin
    p_comb = '0;
    case (cfg[1:0])
      MAC_SINGLE: p_comb = {C3, C2, C1, C0};
      MAC_DUAL:   p_comb = {dual_hi, dual_lo};
      MAC_QUAD:   p_comb = quad_sum;
      default:    p_comb = '0;
    endcase
  end

  // Stage 1: capture the combined product; P holds through idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1   <= '0;
      clr1 <= 1'b0;
      cfg1 <= 2'b00;
      v1   <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        p1   <= p_comb;
        clr1 <= clr;
        cfg1 <= cfg[1:0];
      end
    end
  end

  // Lane boundaries follow the beat's own cfg, not a latched mode.
  mac_seg_adder u_seg_adder (
    .a   (acc_out),
    .b   (p1),
    .cfg (cfg1),
    .sum (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out   <= '0;
      valid_out <= 1'b0;
      cfg_out   <= 2'b00;
    end else begin
      valid_out <= v1;
      if (v1) begin
        acc_out <= clr1 ? p1 : acc_sum;
        cfg_out <= cfg1;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_block.sv
// Self-checking bench for mac_acc_block: directed cases plus randomized beats
// against a lane-arithmetic reference model.
module tb_mac_acc_block;

  logic         clk = 1'b0;
  logic         rst, en, clr;
  logic [2:0]   cfg;
  logic [39:0]  C0, C1, C2, C3;
  logic [159:0] acc_out;
  logic         valid_out;
  logic [1:0]   cfg_out;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [159:0] m_acc = '0;
  logic         m_valid = 1'b0;
  logic [1:0]   m_cfgo = 2'b00;
  logic         q_v = 1'b0, q_clr = 1'b0;
  logic [1:0]   q_cfg = 2'b00;
  logic [159:0] q_p = '0;

  always #5 clk = ~clk;

  mac_acc_block dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .cfg       (cfg),
    .C0        (C0),
    .C1        (C1),
    .C2        (C2),
    .C3        (C3),
    .acc_out   (acc_out),
    .valid_out (valid_out),
    .cfg_out   (cfg_out)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int lane_w(input logic [1:0] cf);
    if (cf == 2'b01) return 80;
    if (cf == 2'b10) return 160;
    return 40;
  endfunction

  function automatic logic [159:0] ref_combine(input logic [1:0] cf,
      input logic [39:0] c0, input logic [39:0] c1, input logic [39:0] c2, input logic [39:0] c3);
    logic [159:0] r0, r1, r2, r3;
    r0 = 160'(c0); r1 = 160'(c1); r2 = 160'(c2); r3 = 160'(c3);
    case (cf)
      2'b00:   return r0 | (r1 << 40) | (r2 << 80) | (r3 << 120);
      2'b01:   return (r0 + r1 * 256) | ((r2 + r3 * 256) << 80);
      2'b10:   return r0 + r1 * 256 + r2 * 65536 + r3 * 16777216;
      default: return '0;
    endcase
  endfunction

  function automatic logic [159:0] ref_add(input logic [159:0] a, input logic [159:0] b, input int w);
    logic [159:0] mask, lane, r;
    r = '0;
    mask = (w == 160) ? {160{1'b1}} : ((160'd1 << w) - 160'd1);
    for (int off = 0; off < 160; off += w) begin
      lane = (((a >> off) & mask) + ((b >> off) & mask)) & mask;
      r = r | (lane << off);
    end
    return r;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare after it.
  task automatic cycle(input logic r, input logic e, input logic c, input logic [2:0] cf,
      input logic [39:0] x0, input logic [39:0] x1, input logic [39:0] x2, input logic [39:0] x3);
    rst = r; en = e; clr = c; cfg = cf; C0 = x0; C1 = x1; C2 = x2; C3 = x3;
    @(posedge clk);
    #1;
    if (r) begin
      m_acc = '0; m_valid = 1'b0; m_cfgo = 2'b00; q_v = 1'b0;
    end else begin
      m_valid = q_v;
      if (q_v) begin
        m_acc  = q_clr ? q_p : ref_add(m_acc, q_p, lane_w(q_cfg));
        m_cfgo = q_cfg;
      end
      q_v = e;
      if (e) begin
        q_p = ref_combine(cf[1:0], x0, x1, x2, x3); q_clr = c; q_cfg = cf[1:0];
      end
    end
    chk("acc_out", acc_out, m_acc);
    chk("valid_out", 160'(valid_out), 160'(m_valid));
    chk("cfg_out", 160'(cfg_out), 160'(m_cfgo));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
  endtask

  task automatic beat(input logic c, input logic [2:0] cf,
      input logic [39:0] x0, input logic [39:0] x1, input logic [39:0] x2, input logic [39:0] x3);
    cycle(1'b0, 1'b1, c, cf, x0, x1, x2, x3);
  endtask

  initial begin
    logic [63:0] r64 [4];
    rst = 1'b1; en = 1'b0; clr = 1'b0; cfg = '0; C0 = '0; C1 = '0; C2 = '0; C3 = '0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 1'b1, 3'b000, 40'd5, 40'd5, 40'd5, 40'd5);
    cycle(1'b1, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    chk("reset_acc", acc_out, 160'd0);

    // SINGLE accumulate
    beat(1'b1, 3'b000, 40'd65025, 40'd65025, 40'd65025, 40'd65025);
    for (int i = 0; i < 3; i++) beat(1'b0, 3'b100, 40'd65025, 40'd65025, 40'd65025, 40'd65025);
    idle(2);
    chk("single_lane0", 160'(acc_out[39:0]), 160'd260100);
    chk("single_lane3", 160'(acc_out[159:120]), 160'd260100);

    // DUAL
    beat(1'b1, 3'b001, 40'd1, 40'd1, 40'd2, 40'd0);
    idle(2);
    chk("dual_lane0", 160'(acc_out[79:0]), 160'd257);
    chk("dual_lane1", 160'(acc_out[159:80]), 160'd2);

    // QUAD
    beat(1'b1, 3'b010, 40'd1, 40'd1, 40'd1, 40'd1);
    idle(2);
    chk("quad_first", acc_out, 160'h0101_0101);
    beat(1'b0, 3'b010, 40'd1, 40'd1, 40'd1, 40'd1);
    idle(2);
    chk("quad_second", acc_out, 160'h0202_0202);

    // carry kill vs propagate
    beat(1'b1, 3'b000, 40'hFF_FFFF_FFFF, '0, '0, '0);
    beat(1'b0, 3'b000, 40'd1, '0, '0, '0);
    idle(2);
    chk("kill_single", acc_out, 160'd0);
    beat(1'b1, 3'b010, 40'hFF_FFFF_FFFF, '0, '0, '0);
    beat(1'b0, 3'b010, 40'd1, '0, '0, '0);
    idle(2);
    chk("carry_quad", acc_out, 160'h100_0000_0000);

    // DUAL boundary: carry crosses bit 40 but not bit 80
    beat(1'b1, 3'b001, 40'hFF_FFFF_FFFF, 40'hFFFF_FFFF, 40'hFF_FFFF_FFFF, 40'hFFFF_FFFF);
    beat(1'b0, 3'b001, 40'd1, '0, '0, '0);
    idle(2);

    // gap and reset
    beat(1'b1, 3'b000, 40'd7, 40'd8, 40'd9, 40'd10);
    idle(2);
    beat(1'b0, 3'b000, 40'd1, 40'd1, 40'd1, 40'd1);
    idle(3);
    chk("gap_lane0", 160'(acc_out[39:0]), 160'd8);
    beat(1'b0, 3'b000, 40'd3, 40'd3, 40'd3, 40'd3);
    cycle(1'b1, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    idle(2);
    chk("rst_drop", acc_out, 160'd0);

    // undefined cfg
    beat(1'b1, 3'b000, 40'd4, 40'd4, 40'd4, 40'd4);
    beat(1'b0, 3'b011, 40'd9, 40'd9, 40'd9, 40'd9);
    idle(2);
    chk("undef_hold", 160'(acc_out[39:0]), 160'd4);
    beat(1'b1, 3'b111, 40'd9, 40'd9, 40'd9, 40'd9);
    idle(2);
    chk("undef_clr", acc_out, 160'd0);
    chk("undef_cfg", 160'(cfg_out), 160'd3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) r64[k] = {$urandom, $urandom};
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
            3'($urandom_range(0, 7)), r64[0][39:0], r64[1][39:0], r64[2][39:0], r64[3][39:0]);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
